// File: rtl/jedro_1_decode_stage_pkg.sv
// Shared encodings for the jedro_1 decode stage: opcodes, instruction classes,
// ALU op codes, immediate formats and the immediate extraction helper.
package jedro_1_decode_stage_pkg;

  localparam int DATA_WIDTH_DEF = 32;

  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_MISCMEM = 7'b0001111;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

  typedef enum logic [3:0] {
    CLS_LOAD    = 4'd0,
    CLS_MISCMEM = 4'd1,
    CLS_OPIMM   = 4'd2,
    CLS_AUIPC   = 4'd3,
    CLS_STORE   = 4'd4,
    CLS_OP      = 4'd5,
    CLS_LUI     = 4'd6,
    CLS_BRANCH  = 4'd7,
    CLS_JALR    = 4'd8,
    CLS_JAL     = 4'd9,
    CLS_SYSTEM  = 4'd10
  } instr_class_e;

  localparam logic [3:0] ALU_ADD = 4'b0000;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_fmt_e;

  function automatic logic [31:0] gen_imm(input logic [31:0] w, input imm_fmt_e fmt);
    logic [31:0] r;
    case (fmt)
      IMM_I:   r = {{20{w[31]}}, w[31:20]};
      IMM_S:   r = {{20{w[31]}}, w[31:25], w[11:7]};
      IMM_B:   r = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      IMM_U:   r = {w[31:12], 12'h000};
      IMM_J:   r = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/jedro_1_decode_comb.sv
// Purely combinational RV32I/RV32E decoder: instruction word in, decoded bundle
// out, including immediate generation and the legality check.
module jedro_1_decode_comb
  import jedro_1_decode_stage_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int ALU_OP_WIDTH   = 4
) (
  input  logic [31:0]               instr_i,
  output logic [3:0]                instr_class_o,
  output logic [ALU_OP_WIDTH-1:0]   alu_op_sel_o,
  output logic                      op_b_imm_o,
  output logic [REG_ADDR_WIDTH-1:0] rs1_addr_o,
  output logic [REG_ADDR_WIDTH-1:0] rs2_addr_o,
  output logic [REG_ADDR_WIDTH-1:0] rd_addr_o,
  output logic                      rd_we_o,
  output logic [DATA_WIDTH-1:0]     imm_o,
  output logic                      illegal_instr_o
);

  localparam bit RVE = (REG_ADDR_WIDTH == 32'sd4);

  logic [6:0]   w_opcode;
  logic [2:0]   w_f3;
  logic [6:0]   w_f7;
  instr_class_e w_class;
  imm_fmt_e     w_fmt;
  logic [3:0]   w_alu;
  logic         w_known, w_bad, w_opb, w_use_rs1, w_use_rs2, w_use_rd, w_writes;
  logic         w_rve_bad, w_illegal;

  assign w_opcode = instr_i[6:0];
  assign w_f3     = instr_i[14:12];
  assign w_f7     = instr_i[31:25];

  // per-opcode class, operand usage and field legality
  always_comb begin
    w_known   = 1'b1;
    w_bad     = 1'b0;
    w_class   = CLS_LOAD;
    w_fmt     = IMM_NONE;
    w_alu     = ALU_ADD;
    w_opb     = 1'b0;
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    w_use_rd  = 1'b0;
    w_writes  = 1'b0;
    case (w_opcode)
      OPC_LOAD: begin
        w_class = CLS_LOAD;  w_fmt = IMM_I; w_opb = 1'b1;
        w_use_rs1 = 1'b1; w_use_rd = 1'b1; w_writes = 1'b1;
        w_bad = (w_f3 == 3'b011) || (w_f3 == 3'b110) || (w_f3 == 3'b111);
      end
      OPC_MISCMEM: begin
        w_class = CLS_MISCMEM; w_fmt = IMM_I;
      end
      OPC_OPIMM: begin
        w_class = CLS_OPIMM; w_fmt = IMM_I; w_opb = 1'b1;
        w_use_rs1 = 1'b1; w_use_rd = 1'b1; w_writes = 1'b1;
        w_alu = {(w_f3 == 3'b101) ? w_f7[5] : 1'b0, w_f3};
        w_bad = ((w_f3 == 3'b001) && (w_f7 != 7'b0000000)) ||
                ((w_f3 == 3'b101) && (w_f7 != 7'b0000000) && (w_f7 != 7'b0100000));
      end
      OPC_AUIPC: begin
        w_class = CLS_AUIPC; w_fmt = IMM_U; w_opb = 1'b1;
        w_use_rd = 1'b1; w_writes = 1'b1;
      end
      OPC_STORE: begin
        w_class = CLS_STORE; w_fmt = IMM_S; w_opb = 1'b1;
        w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
        w_bad = (w_f3 > 3'b010);
      end
      OPC_OP: begin
        w_class = CLS_OP; w_alu = {w_f7[5], w_f3};
        w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_use_rd = 1'b1; w_writes = 1'b1;
        w_bad = !((w_f7 == 7'b0000000) ||
                  ((w_f7 == 7'b0100000) && ((w_f3 == 3'b000) || (w_f3 == 3'b101))));
      end
      OPC_LUI: begin
        w_class = CLS_LUI; w_fmt = IMM_U; w_opb = 1'b1;
        w_use_rd = 1'b1; w_writes = 1'b1;
      end
      OPC_BRANCH: begin
        w_class = CLS_BRANCH; w_fmt = IMM_B;
        w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
        w_bad = (w_f3 == 3'b010) || (w_f3 == 3'b011);
      end
      OPC_JALR: begin
        w_class = CLS_JALR; w_fmt = IMM_I; w_opb = 1'b1;
        w_use_rs1 = 1'b1; w_use_rd = 1'b1; w_writes = 1'b1;
        w_bad = (w_f3 != 3'b000);
      end
      OPC_JAL: begin
        w_class = CLS_JAL; w_fmt = IMM_J; w_opb = 1'b1;
        w_use_rd = 1'b1; w_writes = 1'b1;
      end
      OPC_SYSTEM: begin
        w_class = CLS_SYSTEM; w_fmt = IMM_I;
      end
      default: begin
        w_known = 1'b0;
      end
    endcase
  end

  // RV32E only has x0-x15, so bit 4 of any register field actually used is illegal
  assign w_rve_bad = RVE && ((w_use_rs1 && instr_i[19]) ||
                             (w_use_rs2 && instr_i[24]) ||
                             (w_use_rd  && instr_i[11]));
  assign w_illegal = !w_known || w_bad || w_rve_bad;

  assign instr_class_o   = w_class;
  assign alu_op_sel_o    = ALU_OP_WIDTH'(w_alu);
  assign op_b_imm_o      = w_opb;
  assign rs1_addr_o      = instr_i[15 +: REG_ADDR_WIDTH];
  assign rs2_addr_o      = instr_i[20 +: REG_ADDR_WIDTH];
  assign rd_addr_o       = instr_i[7 +: REG_ADDR_WIDTH];
  assign rd_we_o         = w_writes && !w_illegal;
  assign imm_o           = DATA_WIDTH'($signed(gen_imm(instr_i, w_fmt)));
  assign illegal_instr_o = w_illegal;

endmodule

// File: rtl/jedro_1_decode_stage.sv
// Registered decode stage: wraps the combinational decoder with an input
// handshake, an output register and an optional one-entry skid register.
module jedro_1_decode_stage
  import jedro_1_decode_stage_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int ALU_OP_WIDTH   = 4,
  parameter bit SKID_EN        = 1'b1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [31:0]               instr_i,
  input  logic                      instr_valid_i,
  output logic                      instr_ready_o,
  input  logic                      flush_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [3:0]                instr_class_o,
  output logic [ALU_OP_WIDTH-1:0]   alu_op_sel_o,
  output logic                      op_b_imm_o,
  output logic [REG_ADDR_WIDTH-1:0] rs1_addr_o,
  output logic [REG_ADDR_WIDTH-1:0] rs2_addr_o,
  output logic [REG_ADDR_WIDTH-1:0] rd_addr_o,
  output logic                      rd_we_o,
  output logic [DATA_WIDTH-1:0]     imm_o,
  output logic                      illegal_instr_o
);

  localparam int BW = 4 + ALU_OP_WIDTH + 1 + 3 * REG_ADDR_WIDTH + 1 + DATA_WIDTH + 1;

  logic [3:0]                w_class;
  logic [ALU_OP_WIDTH-1:0]   w_alu;
  logic                      w_opb, w_we, w_ill;
  logic [REG_ADDR_WIDTH-1:0] w_rs1, w_rs2, w_rd;
  logic [DATA_WIDTH-1:0]     w_imm;
  logic [BW-1:0]             w_dec, r_out, r_skid;
  logic                      r_out_valid, r_skid_valid, r_ready;
  logic                      w_accept, w_hold;

  jedro_1_decode_comb #(
    .DATA_WIDTH     (DATA_WIDTH),
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
    .ALU_OP_WIDTH   (ALU_OP_WIDTH)
  ) u_decode (
    .instr_i         (instr_i),
    .instr_class_o   (w_class),
    .alu_op_sel_o    (w_alu),
    .op_b_imm_o      (w_opb),
    .rs1_addr_o      (w_rs1),
    .rs2_addr_o      (w_rs2),
    .rd_addr_o       (w_rd),
    .rd_we_o         (w_we),
    .imm_o           (w_imm),
    .illegal_instr_o (w_ill)
  );

  assign w_dec    = {w_class, w_alu, w_opb, w_rs1, w_rs2, w_rd, w_we, w_imm, w_ill};
  assign w_hold   = r_out_valid && !out_ready_i;
  assign w_accept = instr_valid_i && instr_ready_o;

  // Without the skid entry the skid never fills, so r_ready only masks reset.
  assign instr_ready_o = SKID_EN ? r_ready
                                 : (r_ready && (!r_out_valid || out_ready_i || flush_i));

  // output/skid registers; flush beats both hold and accept
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_ready      <= 1'b0;
      r_out        <= '0;
      r_skid       <= '0;
    end else if (flush_i) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_ready      <= 1'b1;
    end else if (w_hold) begin
      if (w_accept) begin
        r_skid       <= w_dec;
        r_skid_valid <= 1'b1;
        r_ready      <= 1'b0;
      end else begin
        r_ready <= !r_skid_valid;
      end
    end else if (r_skid_valid) begin
      r_out        <= r_skid;
      r_out_valid  <= 1'b1;
      r_skid_valid <= 1'b0;
      r_ready      <= 1'b1;
    end else begin
      r_out_valid <= w_accept;
      r_ready     <= 1'b1;
      if (w_accept) begin
        r_out <= w_dec;
      end else begin
        r_out <= r_out;
      end
    end
  end

  assign out_valid_o = r_out_valid;
  assign {instr_class_o, alu_op_sel_o, op_b_imm_o, rs1_addr_o, rs2_addr_o,
          rd_addr_o, rd_we_o, imm_o, illegal_instr_o} = r_out;

endmodule

// File: tb/tb_jedro_1_decode_stage.sv
// Self-checking bench for jedro_1_decode_stage: directed vector table, hand
// sequences for backpressure/flush/reset, and randomized traffic against a model.
module tb_jedro_1_decode_stage;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0] instr;
  logic        ivalid, iready, flush, ovalid, oready, opb, we, ill;
  logic [3:0]  cls, alu;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm;

  logic [31:0] instr_e;
  logic        ivalid_e, iready_e, flush_e, ovalid_e, oready_e, opb_e, we_e, ill_e;
  logic [3:0]  cls_e, alu_e, rs1_e, rs2_e, rd_e;
  logic [31:0] imm_e;

  jedro_1_decode_stage dut (
    .clk_i(clk), .rst_i(rst), .instr_i(instr), .instr_valid_i(ivalid),
    .instr_ready_o(iready), .flush_i(flush), .out_valid_o(ovalid), .out_ready_i(oready),
    .instr_class_o(cls), .alu_op_sel_o(alu), .op_b_imm_o(opb), .rs1_addr_o(rs1),
    .rs2_addr_o(rs2), .rd_addr_o(rd), .rd_we_o(we), .imm_o(imm), .illegal_instr_o(ill)
  );

  jedro_1_decode_stage #(.REG_ADDR_WIDTH(4), .SKID_EN(1'b0)) dut_e (
    .clk_i(clk), .rst_i(rst), .instr_i(instr_e), .instr_valid_i(ivalid_e),
    .instr_ready_o(iready_e), .flush_i(flush_e), .out_valid_o(ovalid_e), .out_ready_i(oready_e),
    .instr_class_o(cls_e), .alu_op_sel_o(alu_e), .op_b_imm_o(opb_e), .rs1_addr_o(rs1_e),
    .rs2_addr_o(rs2_e), .rd_addr_o(rd_e), .rd_we_o(we_e), .imm_o(imm_e), .illegal_instr_o(ill_e)
  );

  typedef struct packed {
    logic [3:0]  cls;
    logic [3:0]  alu;
    logic        opb;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] imm;
    logic        ill;
  } exp_t;

  typedef struct packed {
    logic [31:0] instr;
    exp_t        e;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  logic [6:0] opcs [11] = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33,
                            7'h37, 7'h63, 7'h67, 7'h6F, 7'h73};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic chk_bundle(input string nm, input exp_t e);
    exp_t a;
    a = '{cls, alu, opb, rs1, rs2, rd, we, imm, ill};
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: actual=%h expected=%h", nm, a, e);
    end
  endtask

  task automatic chk_bundle_e(input string nm, input exp_t e);
    exp_t a;
    a = '{cls_e, alu_e, opb_e, {1'b0, rs1_e}, {1'b0, rs2_e}, {1'b0, rd_e}, we_e, imm_e, ill_e};
    e.rs1[4] = 1'b0; e.rs2[4] = 1'b0; e.rd[4] = 1'b0;
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: actual=%h expected=%h", nm, a, e);
    end
  endtask

  // Reference decoder written from the ISA rules with signed arithmetic.
  function automatic exp_t model(input logic [31:0] w, input bit rve);
    exp_t e;
    logic [2:0] f3;
    logic [6:0] f7;
    int i_imm, hi25, sgn;
    bit u1, u2, ud;
    e = '0; u1 = 0; u2 = 0; ud = 0;
    f3 = w[14:12]; f7 = w[31:25];
    i_imm = $signed(w) >>> 20;
    hi25  = $signed(w) >>> 25;
    sgn   = $signed(w) >>> 31;
    e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.rd = w[11:7];
    case (w[6:0])
      7'h03: begin e.cls = 4'd0; e.imm = i_imm; e.opb = 1; u1 = 1; ud = 1;
                   e.ill = (f3 == 3) || (f3 >= 6); end
      7'h0F: begin e.cls = 4'd1; e.imm = i_imm; end
      7'h13: begin e.cls = 4'd2; e.imm = i_imm; e.opb = 1; u1 = 1; ud = 1;
                   e.alu = (f3 == 5) ? {w[30], f3} : {1'b0, f3};
                   e.ill = (f3 == 1 && f7 != 0) || (f3 == 5 && f7 != 0 && f7 != 7'h20); end
      7'h17: begin e.cls = 4'd3; e.imm = w & 32'hFFFF_F000; e.opb = 1; ud = 1; end
      7'h23: begin e.cls = 4'd4; e.imm = (hi25 << 5) | {27'd0, w[11:7]}; e.opb = 1;
                   u1 = 1; u2 = 1; e.ill = (f3 > 2); end
      7'h33: begin e.cls = 4'd5; e.alu = {w[30], f3}; u1 = 1; u2 = 1; ud = 1;
                   e.ill = !(f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5))); end
      7'h37: begin e.cls = 4'd6; e.imm = w & 32'hFFFF_F000; e.opb = 1; ud = 1; end
      7'h63: begin e.cls = 4'd7; u1 = 1; u2 = 1; e.ill = (f3 == 2) || (f3 == 3);
                   e.imm = (sgn << 12) | {20'd0, w[7], w[30:25], w[11:8], 1'b0}; end
      7'h67: begin e.cls = 4'd8; e.imm = i_imm; e.opb = 1; u1 = 1; ud = 1; e.ill = (f3 != 0); end
      7'h6F: begin e.cls = 4'd9; e.opb = 1; ud = 1;
                   e.imm = (sgn << 20) | {12'd0, w[19:12], w[20], w[30:21], 1'b0}; end
      7'h73: begin e.cls = 4'd10; e.imm = i_imm; end
      default: e.ill = 1;
    endcase
    if (rve && ((u1 && w[19]) || (u2 && w[24]) || (ud && w[11]))) e.ill = 1;
    e.we = ud && !e.ill;
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom();
    if ($urandom_range(0, 3) != 0) w[6:0] = opcs[$urandom_range(0, 10)];
    if ((w[6:0] == 7'h33 || w[6:0] == 7'h13) && $urandom_range(0, 1) == 1)
      w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    return w;
  endfunction

  vec_t tbl [9];
  exp_t q [$];
  exp_t ex;
  int   pops;
  logic [31:0] w1, w2, w3;

  initial begin
    tbl[0] = '{32'hFFF10093, '{4'd2, 4'h0, 1'b1, 5'd2, 5'd31, 5'd1, 1'b1, 32'hFFFFFFFF, 1'b0}};
    tbl[1] = '{32'h402081B3, '{4'd5, 4'h8, 1'b0, 5'd1, 5'd2, 5'd3, 1'b1, 32'h00000000, 1'b0}};
    tbl[2] = '{32'h123452B7, '{4'd6, 4'h0, 1'b1, 5'd8, 5'd3, 5'd5, 1'b1, 32'h12345000, 1'b0}};
    tbl[3] = '{32'h00000000, '{4'd0, 4'h0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h00000000, 1'b1}};
    tbl[4] = '{32'h022081B3, '{4'd5, 4'h0, 1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 32'h00000000, 1'b1}};
    tbl[5] = '{32'hFE208EE3, '{4'd7, 4'h0, 1'b0, 5'd1, 5'd2, 5'd29, 1'b0, 32'hFFFFFFFC, 1'b0}};
    tbl[6] = '{32'h0020A423, '{4'd4, 4'h0, 1'b1, 5'd1, 5'd2, 5'd8, 1'b0, 32'h00000008, 1'b0}};
    tbl[7] = '{32'h40315093, '{4'd2, 4'hD, 1'b1, 5'd2, 5'd3, 5'd1, 1'b1, 32'h00000403, 1'b0}};
    tbl[8] = '{32'h010000EF, '{4'd9, 4'h0, 1'b1, 5'd0, 5'd16, 5'd1, 1'b1, 32'h00000010, 1'b0}};
    w1 = 32'h00100093; w2 = 32'h00200113; w3 = 32'h00300193;

    rst = 1'b1; instr = '0; ivalid = 0; flush = 0; oready = 1;
    instr_e = '0; ivalid_e = 0; flush_e = 0; oready_e = 1;
    tick(); tick();
    chk("rst_valid", ovalid, 0);
    chk("rst_ready", iready, 0);
    chk("rst_ready_e", iready_e, 0);
    chk_bundle("rst_bundle", '0);
    rst = 1'b0;
    #1 chk("rst_fall_ready", iready, 0);
    tick();
    chk("rst_release_ready", iready, 1);
    chk("rst_release_ready_e", iready_e, 1);

    // directed vectors back-to-back at full rate
    for (int i = 0; i < 9; i++) begin
      instr = tbl[i].instr; ivalid = 1;
      tick();
      chk("tbl_valid", ovalid, 1);
      chk_bundle($sformatf("tbl_%0d", i), tbl[i].e);
    end
    ivalid = 0;
    tick();
    chk("tbl_drained", ovalid, 0);

    // backpressure: three words offered while execute stalls
    oready = 0; ivalid = 1; instr = w1;
    #1 chk("bp_ready_w1", iready, 1);
    tick();
    instr = w2;
    #1 chk("bp_ready_w2", iready, 1);
    chk("bp_valid_w1", ovalid, 1);
    tick();
    instr = w3;
    #1 chk("bp_ready_drop", iready, 0);
    chk_bundle("bp_hold_w1", model(w1, 0));
    tick();
    chk("bp_ready_still_low", iready, 0);
    chk_bundle("bp_hold_w1_again", model(w1, 0));
    oready = 1;
    tick();
    chk_bundle("bp_out_w2", model(w2, 0));
    chk("bp_ready_back", iready, 1);
    tick();
    ivalid = 0;
    #1 chk_bundle("bp_out_w3", model(w3, 0));
    chk("bp_valid_w3", ovalid, 1);
    tick();
    chk("bp_no_dup", ovalid, 0);

    // flush with output and skid both full and a word offered
    oready = 0; ivalid = 1; instr = w1;
    tick();
    instr = w2;
    tick();
    instr = w3; flush = 1;
    tick();
    flush = 0; ivalid = 0; oready = 1;
    #1 chk("flush_valid", ovalid, 0);
    chk("flush_ready", iready, 1);
    tick();
    chk("flush_nothing", ovalid, 0);
    ivalid = 1; instr = w1; flush = 1;
    #1 chk("flush_ready_kept", iready, 1);
    tick();
    flush = 0; ivalid = 0;
    #1 chk("flush_discard", ovalid, 0);
    tick();

    // RV32E instance, no skid: x16-x31 illegal, combinational ready
    ivalid_e = 1; instr_e = 32'h002088B3;
    tick();
    chk("rve_x17_ill", ill_e, 1);
    chk("rve_x17_we", we_e, 0);
    chk_bundle_e("rve_x17", model(32'h002088B3, 1));
    instr_e = 32'h002087B3;
    tick();
    ivalid_e = 0;
    chk("rve_x15_ill", ill_e, 0);
    chk_bundle_e("rve_x15", model(32'h002087B3, 1));
    oready_e = 0;
    #1 chk("rve_ready_held", iready_e, 0);
    oready_e = 1;
    #1 chk("rve_ready_drain", iready_e, 1);
    tick();
    chk("rve_drained", ovalid_e, 0);

    // randomized traffic against the model with a scoreboard queue
    pops = 0;
    for (int c = 0; c < 600; c++) begin
      ivalid = ($urandom_range(0, 3) != 0);
      instr  = rand_instr();
      oready = ($urandom_range(0, 2) != 0);
      #1;
      if (ivalid && iready) q.push_back(model(instr, 0));
      if (ovalid && oready) begin
        if (q.size() == 0) begin
          chk("rand_extra_output", 1, 0);
        end else begin
          ex = q.pop_front();
          pops++;
          chk_bundle("rand", ex);
        end
      end
      tick();
    end
    ivalid = 0; oready = 1;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (ovalid) begin
        if (q.size() == 0) begin
          chk("rand_drain_extra", 1, 0);
        end else begin
          ex = q.pop_front();
          pops++;
          chk_bundle("rand_drain", ex);
        end
      end
      tick();
    end
    chk("rand_lost_words", q.size(), 0);
    chk("rand_traffic", (pops > 100) ? 1 : 0, 1);

    // reset in the middle of a stalled stream
    ivalid = 1; oready = 0; instr = w1;
    tick();
    instr = w2;
    tick();
    rst = 1;
    tick();
    chk("mid_rst_valid", ovalid, 0);
    chk("mid_rst_ready", iready, 0);
    chk_bundle("mid_rst_bundle", '0);
    tick();
    chk("mid_rst_ready_hold", iready, 0);
    rst = 0; ivalid = 0;
    #1 chk("mid_rst_fall_ready", iready, 0);
    tick();
    chk("mid_rst_release_ready", iready, 1);
    chk("mid_rst_release_valid", ovalid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
